// File: rtl/tx_arb_pkg.sv
// Shared types and widths for the UART TX FIFO write arbiter.
package tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int BYTE_IDX_W = 2;
    localparam int LEN_W      = 2;
    localparam int NREQ_MAX   = 8;

endpackage

// File: rtl/tx_arb_pick.sv
// Purpose: combinational winner select over the requester valid vector.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when a pick is consumed.
// TX_ARB_ROUND_ROBIN_EN selects round-robin from rr_ptr+1; otherwise lowest index wins.
module tx_arb_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    assign found = |valid;

`ifdef TX_ARB_ROUND_ROBIN_EN
    // Walk offsets downwards so the nearest valid requester after rr_ptr is written last.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (valid[idx]) begin
                winner = IDX_W'(idx);
            end
        end
    end
`else
    logic [IDX_W-1:0] unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;

    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                winner = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/tx_write_arbiter.sv
// Purpose: grants one of NREQ requesters and writes its 1-4 bytes little-endian into the TX FIFO.
// Latency: first byte one cycle after grant, ack with the last byte, one dead IDLE cycle per request.
// Backpressure: fifo_full holds the current byte (no write, no advance); arbitration via TX_ARB_ROUND_ROBIN_EN.
module tx_write_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][31:0] req_data,
    input  logic [NREQ-1:0][1:0]  req_len,
    output logic [NREQ-1:0]       req_ack,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic [7:0]            fifo_wdata,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NREQ);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [31:0]             data_q, data_d;
    logic [LEN_W-1:0]        len_q, len_d;

    logic [IDX_W-1:0]        winner;
    logic                    found;

    tx_arb_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_q),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        byte_idx_d = byte_idx_q;
        rr_ptr_d   = rr_ptr_q;
        data_d     = data_q;
        len_d      = len_q;
        fifo_wen   = 1'b0;
        fifo_wdata = 8'h00;
        req_ack    = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    data_d     = req_data[winner];
                    len_d      = req_len[winner];
                    grant_d    = winner;
                    byte_idx_d = '0;
                    rr_ptr_d   = winner;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!fifo_full) begin
                    fifo_wen   = 1'b1;
                    fifo_wdata = data_q[{byte_idx_q, 3'b000} +: 8];
                    if (byte_idx_q == len_q) begin
                        req_ack[grant_q] = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            byte_idx_q <= '0;
            rr_ptr_q   <= IDX_W'(NREQ - 1);
            data_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            byte_idx_q <= byte_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            data_q     <= data_d;
            len_q      <= len_d;
        end
    end

endmodule

// File: tb/tb_tx_write_arbiter.sv
// Bench for tx_write_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_tx_write_arbiter;

    localparam int N = 3;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0][31:0] req_data;
    logic [N-1:0][1:0]  req_len;
    logic [N-1:0]       req_ack;
    logic               fifo_full;
    logic               fifo_wen;
    logic [7:0]         fifo_wdata;
    logic               busy;

    tx_write_arbiter #(.NREQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_len    (req_len),
        .req_ack    (req_ack),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transfer is just a queue of bytes still owed to one requester.
    logic [7:0]   m_bytes[$];
    bit           m_sending = 0;
    int           m_grant   = 0;
    int           m_last    = N - 1;

    logic [N-1:0] e_ack;
    logic         e_wen;
    logic [7:0]   e_wd;
    logic         e_busy;
    int           w;

    int           wr_cyc[$];
    logic [7:0]   wr_dat[$];
    int           ack_cyc[$];
    logic [N-1:0] ack_bits[$];
    logic [N-1:0] last_ack = '0;

    function automatic int model_pick(input logic [N-1:0] v, input int last);
`ifdef TX_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int i = (last + k) % N;
            if (v[i]) return i;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        e_ack  = '0;
        e_wen  = 1'b0;
        e_wd   = 8'h00;
        e_busy = 1'b0;
        if (rst) begin
            m_sending = 0;
            m_bytes.delete();
            m_last = N - 1;
        end else begin
            e_busy = m_sending;
            if (m_sending) begin
                if (!fifo_full) begin
                    e_wen = 1'b1;
                    e_wd  = m_bytes.pop_front();
                    if (m_bytes.size() == 0) begin
                        e_ack[m_grant] = 1'b1;
                        m_sending = 0;
                    end
                end
            end else if (|req_valid) begin
                w = model_pick(req_valid, m_last);
                for (int b = 0; b <= int'(req_len[w]); b++) begin
                    m_bytes.push_back(req_data[w][8*b +: 8]);
                end
                m_grant   = w;
                m_last    = w;
                m_sending = 1;
            end
        end
        chk("fifo_wen", 32'(fifo_wen), 32'(e_wen));
        chk("fifo_wdata", 32'(fifo_wdata), 32'(e_wd));
        chk("req_ack", 32'(req_ack), 32'(e_ack));
        chk("busy", 32'(busy), 32'(e_busy));
        if (fifo_wen === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(fifo_wdata);
        end
        if (req_ack != '0) begin
            ack_cyc.push_back(cyc);
            ack_bits.push_back(req_ack);
        end
        last_ack = req_ack;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cyc.delete();
        wr_dat.delete();
        ack_cyc.delete();
        ack_bits.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic wait_ack(input int idx, input int limit);
        bit got;
        got = 0;
        for (int k = 0; k < limit && !got; k++) begin
            @(negedge clk);
            if (req_ack[idx] === 1'b1) got = 1;
            step();
        end
        req_valid[idx] = 1'b0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: requester %0d got no ack within %0d cycles", idx, limit);
        end
    endtask

    int t0;
    logic [7:0] exp_b[4];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_len   = '0;
        fifo_full = 1'b0;
        step();
        @(negedge clk);
        chk("reset_wen", 32'(fifo_wen), 32'd0);
        chk("reset_ack", 32'(req_ack), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wdata", 32'(fifo_wdata), 32'd0);
        do_reset();

        // 1: four bytes, FIFO never full
        req_data[0] = 32'hDDCCBBAA; req_len[0] = 2'd3; req_valid[0] = 1'b1;
        t0 = cyc;
        wait_ack(0, 20);
        @(negedge clk);
        chk("s1_busy_c5", 32'(busy), 32'd0);
        chk("s1_nwr", wr_dat.size(), 32'd4);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        for (int i = 0; i < 4 && i < wr_dat.size(); i++) begin
            chk("s1_byte", 32'(wr_dat[i]), 32'(exp_b[i]));
            chk("s1_byte_cyc", wr_cyc[i] - t0, i + 1);
        end
        chk("s1_nack", ack_cyc.size(), 32'd1);
        if (ack_cyc.size() > 0) begin
            chk("s1_ack_cyc", ack_cyc[0] - t0, 32'd4);
            chk("s1_ack_bits", 32'(ack_bits[0]), 32'b001);
        end

        // 2: single byte behind three full cycles
        do_reset();
        req_data[0] = 32'h00000041; req_len[0] = 2'd0; req_valid[0] = 1'b1;
        t0 = cyc;
        step(); fifo_full = 1'b1;
        step();
        step();
        step(); fifo_full = 1'b0;
        wait_ack(0, 20);
        chk("s2_nwr", wr_dat.size(), 32'd1);
        if (wr_dat.size() > 0) begin
            chk("s2_byte", 32'(wr_dat[0]), 32'h41);
            chk("s2_byte_cyc", wr_cyc[0] - t0, 32'd4);
        end
        chk("s2_nack", ack_cyc.size(), 32'd1);
        if (ack_cyc.size() > 0) chk("s2_ack_cyc", ack_cyc[0] - t0, 32'd4);

        // 3: two requesters valid continuously
        do_reset();
        req_data[0] = 32'h000000A0; req_len[0] = 2'd0;
        req_data[1] = 32'h000000B1; req_len[1] = 2'd0;
        req_valid = 3'b011;
        t0 = cyc;
        repeat (10) step();
        req_valid = '0;
        step();
        step();
        chk("s3_nack", ack_cyc.size(), 32'd5);
        if (ack_cyc.size() >= 4) begin
            chk("s3_first_ack_cyc", ack_cyc[0] - t0, 32'd1);
`ifdef TX_ARB_ROUND_ROBIN_EN
            chk("s3_grant0", 32'(ack_bits[0]), 32'b001);
            chk("s3_grant1", 32'(ack_bits[1]), 32'b010);
            chk("s3_grant2", 32'(ack_bits[2]), 32'b001);
            chk("s3_grant3", 32'(ack_bits[3]), 32'b010);
`else
            chk("s3_grant0", 32'(ack_bits[0]), 32'b001);
            chk("s3_grant1", 32'(ack_bits[1]), 32'b001);
            chk("s3_grant2", 32'(ack_bits[2]), 32'b001);
            chk("s3_grant3", 32'(ack_bits[3]), 32'b001);
`endif
        end

        // 4: payload changes and valid drops after grant
        do_reset();
        req_data[1] = 32'h44332211; req_len[1] = 2'd3; req_valid[1] = 1'b1;
        t0 = cyc;
        step();
        step();
        req_data[1] = 32'hFFFFFFFF; req_len[1] = 2'd0; req_valid[1] = 1'b0;
        repeat (4) step();
        chk("s4_nwr", wr_dat.size(), 32'd4);
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4 && i < wr_dat.size(); i++) begin
            chk("s4_byte", 32'(wr_dat[i]), 32'(exp_b[i]));
        end
        chk("s4_nack", ack_cyc.size(), 32'd1);
        if (ack_cyc.size() > 0) begin
            chk("s4_ack_cyc", ack_cyc[0] - t0, 32'd4);
            chk("s4_ack_bits", 32'(ack_bits[0]), 32'b010);
        end

        // 5: reset in the middle of a 4-byte transfer
        do_reset();
        req_data[0] = 32'h87654321; req_len[0] = 2'd3; req_valid[0] = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("s5_wen_in_rst", 32'(fifo_wen), 32'd0);
        chk("s5_busy_in_rst", 32'(busy), 32'd0);
        step();
        rst = 1'b0; req_valid = '0;
        step();
        chk("s5_nwr", wr_dat.size(), 32'd2);
        if (wr_dat.size() >= 2) begin
            chk("s5_byte0", 32'(wr_dat[0]), 32'h21);
            chk("s5_byte1", 32'(wr_dat[1]), 32'h43);
        end
        chk("s5_nack", ack_cyc.size(), 32'd0);
        clear_logs();
        req_data[0] = 32'h0000BEEF; req_len[0] = 2'd1; req_valid[0] = 1'b1;
        wait_ack(0, 20);
        chk("s5_new_nwr", wr_dat.size(), 32'd2);
        if (wr_dat.size() >= 2) begin
            chk("s5_new_byte0", 32'(wr_dat[0]), 32'hEF);
            chk("s5_new_byte1", 32'(wr_dat[1]), 32'hBE);
        end

        // Random traffic with random backpressure and occasional reset.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            step();
            rst       = ($urandom_range(0, 599) == 0);
            fifo_full = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_ack[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) == 0);
                    req_data[i]  = $urandom;
                    req_len[i]   = 2'($urandom_range(0, 3));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i]  = $urandom;
                        req_len[i]   = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req_data[i] = $urandom;
                    req_len[i]  = 2'($urandom_range(0, 3));
                end
            end
        end
        rst = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
